// File: rtl/renode_axi_manager_engine_if.sv
// AXI4 single-beat channel bundle shared by the manager engine and its subordinate.
interface renode_axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport manager (
    output awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport subordinate (
    input  awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/renode_axi_manager_engine.sv
// Turns one sized register command into a single-beat AXI4 read or write and
// returns a right-aligned response; illegal sizes/alignments fail without bus traffic.
module renode_axi_manager_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_size,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [63:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [15:0]           err_count,
  renode_axi_if.manager         m_axi_if
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [63:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;
  logic [15:0]             err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;

  logic                    accept;
  logic [2:0]              acc_mask;
  logic                    too_big;
  logic                    cmd_illegal;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [63:0] d,
                                                      input logic [OFF_W-1:0] off);
    return DATA_WIDTH'(d << {off, 3'b000});
  endfunction

  function automatic logic [STRB_W-1:0] lane_strb(input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off);
    return STRB_W'(((16'd1 << (5'd1 << size)) - 16'd1) << off);
  endfunction

  function automatic logic [63:0] lane_extract(input logic [DATA_WIDTH-1:0] d,
                                               input logic [1:0] size,
                                               input logic [OFF_W-1:0] off);
    logic [63:0] wide;
    logic [63:0] mask;
    wide = 64'(d >> {off, 3'b000});
    mask = (size == 2'd3) ? {64{1'b1}} : ((64'd1 << (7'd8 << size)) - 64'd1);
    return wide & mask;
  endfunction

  // A command fails up front when it is wider than the bus or not size-aligned.
  assign accept      = cmd_valid && cmd_ready_q;
  assign acc_mask    = 3'((4'd1 << cmd_size) - 4'd1);
  assign too_big     = (32'd1 << cmd_size) > 32'(STRB_W);
  assign cmd_illegal = too_big || ((cmd_addr[2:0] & acc_mask) != 3'd0);

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    err_count_d = err_count_q;
    addr_d      = addr_q;
    size_d      = size_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = cmd_addr;
          size_d  = cmd_size;
          off_d   = cmd_addr[OFF_W-1:0];
          wdata_d = lane_data(cmd_wdata, cmd_addr[OFF_W-1:0]);
          wstrb_d = lane_strb(cmd_size, cmd_addr[OFF_W-1:0]);
          if (cmd_illegal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 64'd0;
          end else if (cmd_write) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // AW and W retire independently; a cleared valid marks that channel as done.
        if (m_axi_if.awready) awvalid_d = 1'b0;
        if (m_axi_if.wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_if.awready) && (!wvalid_q || m_axi_if.wready)) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (m_axi_if.bvalid) begin
          state_d     = RESP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = m_axi_if.bresp[1];
          rsp_rdata_d = 64'd0;
        end
      end
      RADDR: begin
        if (m_axi_if.arready) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA: begin
        if (m_axi_if.rvalid) begin
          state_d     = RESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = m_axi_if.rresp[1];
          rsp_rdata_d = m_axi_if.rresp[1] ? 64'd0 : lane_extract(m_axi_if.rdata, size_q, off_q);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          if (rsp_error_q) err_count_d = sat_inc(err_count_q);
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_error_q <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      err_count_q <= err_count_d;
    end
  end

  // Command payload is only meaningful while its transaction is live, so it is not reset.
  always_ff @(posedge aclk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    off_q   <= off_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign err_count = err_count_q;

  assign m_axi_if.awid    = {ID_WIDTH{1'b0}};
  assign m_axi_if.awaddr  = addr_q;
  assign m_axi_if.awlen   = 8'd0;
  assign m_axi_if.awsize  = {1'b0, size_q};
  assign m_axi_if.awburst = 2'b01;
  assign m_axi_if.awprot  = 3'd0;
  assign m_axi_if.awvalid = awvalid_q;
  assign m_axi_if.wdata   = wdata_q;
  assign m_axi_if.wstrb   = wstrb_q;
  assign m_axi_if.wlast   = 1'b1;
  assign m_axi_if.wvalid  = wvalid_q;
  assign m_axi_if.bready  = bready_q;
  assign m_axi_if.arid    = {ID_WIDTH{1'b0}};
  assign m_axi_if.araddr  = addr_q;
  assign m_axi_if.arlen   = 8'd0;
  assign m_axi_if.arsize  = {1'b0, size_q};
  assign m_axi_if.arburst = 2'b01;
  assign m_axi_if.arprot  = 3'd0;
  assign m_axi_if.arvalid = arvalid_q;
  assign m_axi_if.rready  = rready_q;
endmodule

// File: tb/tb_renode_axi_manager_engine.sv
// Randomized bench for renode_axi_manager_engine with a byte-lane reference model
// and a cycle-stepped AXI subordinate.
module tb_renode_axi_manager_engine;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic [15:0] err_count;

  int checks = 0;
  int passed = 0;
  int exp_err = 0;

  // observations from the last run_txn
  bit          obs_tmo;
  int          obs_rsp_cyc, obs_aw_c, obs_w_c, obs_held, obs_unstable;
  bit          obs_aw_seen, obs_w_seen, obs_ar_seen;
  logic [63:0] obs_rdata;
  logic        obs_err;
  logic        obs_post_valid, obs_post_ready;
  logic [31:0] obs_awaddr, obs_araddr;
  logic [2:0]  obs_awsize, obs_arsize;
  logic [17:0] obs_awmisc, obs_armisc;
  logic [63:0] obs_wdata;
  logic [7:0]  obs_wstrb;
  logic        obs_wlast;

  always #5 clk = ~clk;

  renode_axi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  renode_axi_manager_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk(clk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .err_count(err_count),
    .m_axi_if(axi)
  );

  task automatic clear_sub();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 64'd0; axi.rresp = 2'b00;
  endtask

  // Issues one command and plays the subordinate cycle by cycle; cycle 1 is the
  // first cycle after the accepting edge.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [63:0] wd, input int aw_dly, input int w_dly,
                         input int ar_dly, input int x_dly, input logic [1:0] resp,
                         input logic [63:0] rbus, input int hold);
    int t, ar_c, x_c, held;
    bit done, pv_aw, pv_w, pv_ar, pv_b, pv_r, pv_rsp;
    logic [51:0] aw_pk, ar_pk;
    logic [72:0] w_pk;
    logic [64:0] rsp_pk;
    obs_tmo = 1'b0; obs_rsp_cyc = -1; obs_aw_c = -1; obs_w_c = -1; obs_unstable = 0;
    obs_aw_seen = 1'b0; obs_w_seen = 1'b0; obs_ar_seen = 1'b0;
    obs_rdata = 'x; obs_err = 1'bx; obs_post_valid = 1'bx; obs_post_ready = 1'bx;
    ar_c = -1; x_c = -1; held = 0; done = 1'b0;
    pv_aw = 0; pv_w = 0; pv_ar = 0; pv_b = 0; pv_r = 0; pv_rsp = 0;
    aw_pk = '0; ar_pk = '0; w_pk = '0; rsp_pk = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = ad; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = {$urandom, $urandom};
    t = 1;
    while (!done && t < 200) begin
      if (pv_aw && axi.awready) obs_aw_c = t - 1;
      if (pv_w && axi.wready) obs_w_c = t - 1;
      if (pv_ar && axi.arready) ar_c = t - 1;
      if ((pv_b && axi.bvalid) || (pv_r && axi.rvalid)) x_c = t - 1;
      if (pv_rsp && rsp_ready) begin
        done = 1'b1;
        obs_post_valid = rsp_valid;
        obs_post_ready = cmd_ready;
      end else begin
        if (cmd_ready) obs_unstable++;
        if (axi.awvalid) begin
          if (obs_aw_c >= 0) obs_unstable++;
          if (!obs_aw_seen) begin
            obs_aw_seen = 1'b1;
            aw_pk = {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awprot};
            obs_awaddr = axi.awaddr; obs_awsize = axi.awsize;
            obs_awmisc = {axi.awid, axi.awlen, axi.awburst, axi.awprot, axi.wlast};
          end else if (aw_pk !== {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awprot})
            obs_unstable++;
        end
        if (axi.wvalid) begin
          if (obs_w_c >= 0) obs_unstable++;
          if (!obs_w_seen) begin
            obs_w_seen = 1'b1;
            w_pk = {axi.wdata, axi.wstrb, axi.wlast};
            obs_wdata = axi.wdata; obs_wstrb = axi.wstrb; obs_wlast = axi.wlast;
          end else if (w_pk !== {axi.wdata, axi.wstrb, axi.wlast}) obs_unstable++;
        end
        if (axi.arvalid) begin
          if (ar_c >= 0) obs_unstable++;
          if (!obs_ar_seen) begin
            obs_ar_seen = 1'b1;
            ar_pk = {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arprot};
            obs_araddr = axi.araddr; obs_arsize = axi.arsize;
            obs_armisc = {axi.arid, axi.arlen, axi.arburst, axi.arprot, 1'b1};
          end else if (ar_pk !== {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arprot})
            obs_unstable++;
        end
        if (rsp_valid) begin
          if (obs_rsp_cyc < 0) begin
            obs_rsp_cyc = t; obs_rdata = rsp_rdata; obs_err = rsp_error;
            rsp_pk = {rsp_rdata, rsp_error};
          end else if (rsp_pk !== {rsp_rdata, rsp_error}) obs_unstable++;
        end
        axi.awready = axi.awvalid && (obs_aw_c < 0) && (t >= 1 + aw_dly);
        axi.wready  = axi.wvalid && (obs_w_c < 0) && (t >= 1 + w_dly);
        axi.arready = axi.arvalid && (ar_c < 0) && (t >= 1 + ar_dly);
        axi.bvalid  = wr && (obs_aw_c >= 0) && (obs_w_c >= 0) && (x_c < 0) &&
                      (t >= ((obs_aw_c > obs_w_c) ? obs_aw_c : obs_w_c) + 1 + x_dly);
        axi.bresp   = resp;
        axi.rvalid  = !wr && (ar_c >= 0) && (x_c < 0) && (t >= ar_c + 1 + x_dly);
        axi.rresp   = resp;
        axi.rdata   = rbus;
        rsp_ready   = rsp_valid && (held >= hold);
        if (rsp_valid) held++;
        pv_aw = axi.awvalid; pv_w = axi.wvalid; pv_ar = axi.arvalid;
        pv_b = axi.bready; pv_r = axi.rready; pv_rsp = rsp_valid;
        t++;
        @(negedge clk);
      end
    end
    obs_held = held;
    if (!done) obs_tmo = 1'b1;
    rsp_ready = 1'b0;
    clear_sub();
  endtask

  task automatic test_reset();
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
    cmd_addr = 32'd0; cmd_wdata = 64'd0; rsp_ready = 1'b0; clear_sub();
    repeat (3) @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid, rsp_error} !== 3'b000)
      $display("FAIL reset_flags got=%b want=000", {cmd_ready, rsp_valid, rsp_error}); else passed++;
    checks++; if (rsp_rdata !== 64'd0) $display("FAIL reset_rdata got=%h want=0", rsp_rdata); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL reset_errcnt got=%0d want=0", err_count); else passed++;
    checks++; if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0)
      $display("FAIL reset_axi got=%b want=00000",
               {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}); else passed++;
    areset = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got=%b want=1", cmd_ready); else passed++;
  endtask

  task automatic test_write_aligned_word();
    run_txn(1'b1, 2'd2, 32'h1004, 64'hAABBCCDD, 0, 0, 0, 0, 2'b00, 64'd0, 0);
    checks++; if (obs_tmo !== 1'b0) $display("FAIL wr_timeout got=1 want=0"); else passed++;
    checks++; if (obs_rsp_cyc != 3) $display("FAIL wr_latency got=%0d want=3", obs_rsp_cyc); else passed++;
    checks++; if (obs_wdata !== 64'hAABBCCDD_00000000)
      $display("FAIL wr_wdata got=%h want=aabbccdd00000000", obs_wdata); else passed++;
    checks++; if (obs_wstrb !== 8'hF0) $display("FAIL wr_wstrb got=%h want=f0", obs_wstrb); else passed++;
    checks++; if ({obs_awaddr, obs_awsize} !== {32'h1004, 3'd2})
      $display("FAIL wr_aw got=%h/%0d want=1004/2", obs_awaddr, obs_awsize); else passed++;
    checks++; if (obs_awmisc !== {4'd0, 8'd0, 2'b01, 3'd0, 1'b1})
      $display("FAIL wr_fixed_fields got=%h want=%h", obs_awmisc, {4'd0, 8'd0, 2'b01, 3'd0, 1'b1}); else passed++;
    checks++; if ({obs_err, obs_rdata} !== {1'b0, 64'd0})
      $display("FAIL wr_rsp got=%b/%h want=0/0", obs_err, obs_rdata); else passed++;
    checks++; if ({obs_post_valid, obs_post_ready} !== 2'b01)
      $display("FAIL wr_post got=%b want=01", {obs_post_valid, obs_post_ready}); else passed++;
  endtask

  task automatic test_read_byte();
    run_txn(1'b0, 2'd0, 32'h2003, 64'd0, 0, 0, 0, 0, 2'b00, 64'h0000_0000_5A00_0000, 0);
    checks++; if (obs_rsp_cyc != 3) $display("FAIL rd_latency got=%0d want=3", obs_rsp_cyc); else passed++;
    checks++; if ({obs_err, obs_rdata} !== {1'b0, 64'h5A})
      $display("FAIL rd_byte got=%b/%h want=0/5a", obs_err, obs_rdata); else passed++;
    checks++; if ({obs_araddr, obs_arsize} !== {32'h2003, 3'd0})
      $display("FAIL rd_ar got=%h/%0d want=2003/0", obs_araddr, obs_arsize); else passed++;
    checks++; if (obs_armisc !== {4'd0, 8'd0, 2'b01, 3'd0, 1'b1})
      $display("FAIL rd_fixed_fields got=%h", obs_armisc); else passed++;
  endtask

  task automatic test_misaligned();
    run_txn(1'b1, 2'd1, 32'h3001, 64'h1234, 0, 0, 0, 0, 2'b00, 64'd0, 0);
    exp_err++;
    checks++; if (obs_rsp_cyc != 1) $display("FAIL mis_latency got=%0d want=1", obs_rsp_cyc); else passed++;
    checks++; if ({obs_err, obs_rdata} !== {1'b1, 64'd0})
      $display("FAIL mis_rsp got=%b/%h want=1/0", obs_err, obs_rdata); else passed++;
    checks++; if ({obs_aw_seen, obs_w_seen, obs_ar_seen} !== 3'b000)
      $display("FAIL mis_no_axi got=%b want=000", {obs_aw_seen, obs_w_seen, obs_ar_seen}); else passed++;
    checks++; if (err_count !== 16'(exp_err)) $display("FAIL mis_errcnt got=%0d want=%0d", err_count, exp_err); else passed++;
  endtask

  task automatic test_w_before_aw_slverr();
    run_txn(1'b1, 2'd3, 32'h5008, 64'h0123_4567_89AB_CDEF, 3, 0, 0, 1, 2'b10, 64'd0, 0);
    exp_err++;
    checks++; if ({obs_w_c, obs_aw_c} != {32'd1, 32'd4})
      $display("FAIL wfirst_order got=w%0d/aw%0d want=w1/aw4", obs_w_c, obs_aw_c); else passed++;
    checks++; if (obs_unstable != 0) $display("FAIL wfirst_stable got=%0d want=0", obs_unstable); else passed++;
    checks++; if ({obs_err, obs_wstrb, obs_wdata} !== {1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF})
      $display("FAIL wfirst_rsp got=%b/%h/%h", obs_err, obs_wstrb, obs_wdata); else passed++;
    checks++; if (obs_post_valid !== 1'b0) $display("FAIL wfirst_single got=%b want=0", obs_post_valid); else passed++;
    checks++; if (err_count !== 16'(exp_err)) $display("FAIL wfirst_errcnt got=%0d want=%0d", err_count, exp_err); else passed++;
  endtask

  task automatic test_aw_before_w();
    run_txn(1'b1, 2'd1, 32'h6006, 64'hBEEF, 0, 2, 0, 0, 2'b01, 64'd0, 0);
    checks++; if ({obs_aw_c, obs_w_c} != {32'd1, 32'd3})
      $display("FAIL awfirst_order got=aw%0d/w%0d want=aw1/w3", obs_aw_c, obs_w_c); else passed++;
    checks++; if ({obs_unstable, obs_err, obs_wstrb, obs_wdata} !== {32'd0, 1'b0, 8'hC0, 64'hBEEF_0000_0000_0000})
      $display("FAIL awfirst_rsp got=%0d/%b/%h/%h", obs_unstable, obs_err, obs_wstrb, obs_wdata); else passed++;
  endtask

  task automatic test_rsp_backpressure();
    run_txn(1'b0, 2'd1, 32'h7002, 64'd0, 0, 0, 0, 0, 2'b00, 64'h1111_2222_3344_5566, 5);
    checks++; if (obs_held != 6) $display("FAIL bp_held got=%0d want=6", obs_held); else passed++;
    checks++; if (obs_unstable != 0) $display("FAIL bp_stable got=%0d want=0", obs_unstable); else passed++;
    checks++; if ({obs_err, obs_rdata} !== {1'b0, 64'h3344})
      $display("FAIL bp_data got=%b/%h want=0/3344", obs_err, obs_rdata); else passed++;
  endtask

  task automatic test_random();
    logic wr; logic [1:0] sz, rsp; logic [31:0] ad; logic [63:0] wd, rb, exp_wd, exp_rd;
    logic [7:0] exp_st; int bytes, off; bit illegal; logic exp_e;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom); sz = 2'($urandom); ad = $urandom;
      bytes = 1 << sz;
      if ($urandom_range(3) != 0) ad = ad & ~(32'(bytes) - 32'd1);
      wd = {$urandom, $urandom}; rb = {$urandom, $urandom}; rsp = 2'($urandom);
      off = int'(ad % 8);
      illegal = (ad % 32'(bytes)) != 0;
      exp_wd = '0; exp_st = '0; exp_rd = '0;
      for (int l = 0; l < 8; l++) begin
        if (l >= off) exp_wd[8*l +: 8] = wd[8*(l-off) +: 8];
        if (l >= off && l < off + bytes) exp_st[l] = 1'b1;
      end
      exp_e = illegal ? 1'b1 : rsp[1];
      if (!illegal && !wr && !rsp[1])
        for (int i = 0; i < bytes; i++) exp_rd[8*i +: 8] = rb[8*(off+i) +: 8];
      run_txn(wr, sz, ad, wd, $urandom_range(3), $urandom_range(3), $urandom_range(3),
              $urandom_range(3), rsp, rb, $urandom_range(2));
      if (exp_e) exp_err++;
      checks++; if (obs_tmo !== 1'b0) $display("FAIL rnd%0d_timeout", n); else passed++;
      checks++; if ({obs_err, obs_rdata} !== {exp_e, exp_rd})
        $display("FAIL rnd%0d_rsp got=%b/%h want=%b/%h", n, obs_err, obs_rdata, exp_e, exp_rd); else passed++;
      checks++; if ({obs_aw_seen, obs_w_seen, obs_ar_seen} !== (illegal ? 3'b000 : (wr ? 3'b110 : 3'b001)))
        $display("FAIL rnd%0d_channels got=%b", n, {obs_aw_seen, obs_w_seen, obs_ar_seen}); else passed++;
      checks++; if (obs_unstable != 0) $display("FAIL rnd%0d_stable got=%0d want=0", n, obs_unstable); else passed++;
      if (!illegal && wr) begin
        checks++; if ({obs_wdata, obs_wstrb, obs_awaddr, obs_awsize} !== {exp_wd, exp_st, ad, 1'b0, sz})
          $display("FAIL rnd%0d_wr got=%h/%h/%h want=%h/%h/%h", n, obs_wdata, obs_wstrb, obs_awaddr,
                   exp_wd, exp_st, ad); else passed++;
      end
      if (!illegal && !wr) begin
        checks++; if ({obs_araddr, obs_arsize} !== {ad, 1'b0, sz})
          $display("FAIL rnd%0d_ar got=%h/%0d want=%h/%0d", n, obs_araddr, obs_arsize, ad, sz); else passed++;
      end
      checks++; if (err_count !== 16'(exp_err))
        $display("FAIL rnd%0d_errcnt got=%0d want=%0d", n, err_count, exp_err); else passed++;
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h4000;
    @(negedge clk);
    cmd_valid = 1'b0;
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    checks++; if (axi.rready !== 1'b1) $display("FAIL rstmid_in_rdata got=%b want=1", axi.rready); else passed++;
    areset = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid, rsp_error, rsp_rdata, err_count} !== 83'd0)
      $display("FAIL rstmid_outputs got=%b%b%b/%h/%0d", cmd_ready, rsp_valid, rsp_error, rsp_rdata, err_count);
    else passed++;
    checks++; if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0)
      $display("FAIL rstmid_axi got=%b", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
    else passed++;
    exp_err = 0;
    areset = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    clear_sub();
    @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10)
      $display("FAIL rstmid_abandon got=%b want=10", {cmd_ready, rsp_valid}); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_aligned_word();
    test_read_byte();
    test_misaligned();
    test_w_before_aw_slverr();
    test_aw_before_w();
    test_rsp_backpressure();
    test_random();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/renode_axi_manager_engine.md
RENODE_AXI_MANAGER_ENGINE -- requirements
Module: renode_axi_manager_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width; equals the renode_axi_if address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width in bits; legal values are 32 and 64.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width; it drives constant ID 0.
REQ-004 aclk  input  1  sole clock; all logic is on its rising edge.
REQ-005 areset  input  1  reset, synchronous and active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_size  input  2  0 = Byte, 1 = Word, 2 = DoubleWord, 3 = QuadWord; access is 1<<cmd_size bytes.
REQ-010 cmd_addr  input  ADDR_WIDTH  byte address.
REQ-011 cmd_wdata  input  64  write data, right-aligned.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-014 rsp_rdata  output  64  read data, right-aligned and zero-extended; 0 for writes and errors.
REQ-015 rsp_error  output  1  1 = failed access.
REQ-016 err_count  output  16  saturating count of error responses delivered.
REQ-017 m_axi_if  interface  renode_axi_if  AXI4 manager port; the block drives aw*, w*, ar*, bready and rready.

Function
REQ-018 SHALL use states IDLE, WRITE, WRESP, RADDR, RDATA, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-019 On command accept, SHALL register the command and compute off = cmd_addr mod (DATA_WIDTH/8).
REQ-020 Accept SHALL go to RESP with rsp_error=1, rsp_rdata=0, and no AXI activity when either holds: size bytes > DATA_WIDTH/8, or cmd_addr is not aligned to the size.
REQ-021 A legal write SHALL go to WRITE and assert awvalid and wvalid on the next cycle.
REQ-022 Write AXI fields: awaddr=cmd_addr, awsize=cmd_size, awlen=0, awburst=INCR, awprot=0, wlast=1.
REQ-023 Write data fields: wdata = cmd_wdata << (8*off), truncated to DATA_WIDTH; wstrb = ((1<<bytes)-1) << off.
REQ-024 In WRITE, awvalid and wvalid SHALL each drop independently after their own handshake; payloads stay stable while pending; AW-first, W-first and same-cycle handshakes are all legal.
REQ-025 When both AW and W handshakes are done, SHALL go to WRESP with bready=1.
REQ-026 On bvalid&&bready, rsp_error SHALL be bresp[1] (SLVERR/DECERR -> 1, OKAY/EXOKAY -> 0); then go to RESP.
REQ-027 A legal read SHALL go to RADDR with arvalid=1; araddr and arsize use the same rules as write; arlen=0, arburst=INCR.
REQ-028 On ar handshake, SHALL go to RDATA with rready=1.
REQ-029 On rvalid&&rready, SHALL capture rsp_rdata = (rdata >> 8*off) masked to the access size, and rsp_error = rresp[1]; then go to RESP.
REQ-030 bready SHALL be 1 only in WRESP and rready only in RDATA; AXI valids SHALL be 0 in all other states.
REQ-031 In RESP, rsp_valid=1 with stable rsp_rdata and rsp_error until rsp_ready; then go to IDLE, with cmd_ready=1 on the following cycle.
REQ-032 Latency with an always-ready subordinate: accept at cycle 0, A/W or AR handshake at cycle 1, B or R at cycle 2, rsp_valid at cycle 3. Illegal command: rsp_valid at cycle 1.
REQ-033 err_count SHALL increment on every rsp handshake with rsp_error=1 and saturate at 0xFFFF.
REQ-034 Exactly one transaction SHALL be outstanding at a time; no command is accepted before its response handshake completes.

Reset
REQ-035 On any clock edge with areset=1: state=IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, err_count=0, all AXI valid/ready outputs=0; cmd_ready=1 on the first cycle after deassertion.
REQ-036 Reset mid-transaction SHALL abandon the AXI transfer with no response generated; the bench SHALL not expect its B/R completion.

Verification
REQ-037 Write, size=2, addr=0x1004, wdata=0xAABBCCDD, DATA_WIDTH=64 -> wdata=0xAABBCCDD_00000000, wstrb=0xF0, awsize=2, rsp_error=0 at cycle 3.
REQ-038 Read, size=0, addr=0x2003, rdata=0x0000_0000_5A00_0000 -> rsp_rdata=0x5A, rsp_error=0.
REQ-039 Write, size=1, addr=0x3001 (misaligned) -> rsp_valid at cycle 1, rsp_error=1, no awvalid, err_count=1.
REQ-040 W accepted 3 cycles before AW, then bresp=SLVERR -> wvalid held stable until wready, single response with rsp_error=1.
REQ-041 rsp_ready held low for 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout; areset during RDATA -> all outputs at reset values the next cycle.
